// File: rtl/funnel_pkg.sv
// Shared definitions for the funnel shifter pipeline: shift-mode encodings.
package funnel_pkg;

  localparam int MODE_W = 3;

  // Codes 5..7 are reserved and pass the operand through unshifted.
  typedef enum logic [MODE_W-1:0] {
    MODE_SLL = 3'd0,
    MODE_SRL = 3'd1,
    MODE_SRA = 3'd2,
    MODE_ROL = 3'd3,
    MODE_ROR = 3'd4
  } shift_mode_e;

endpackage

// File: rtl/funnel_shift_pipe_if.sv
// Valid/ready operation and result bundle for funnel_shift_pipe.
// out_ovf exists only when FSHIFT_OVF_EN is defined.
interface funnel_shift_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  localparam int SH_W = $clog2(2 * WIDTH);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic [2:0]         in_mode;
  logic [SH_W-1:0]    in_shift;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_data;
  logic [TAG_W-1:0]   out_tag;
`ifdef FSHIFT_OVF_EN
  logic               out_ovf;
`endif

  modport master (
    output in_valid, in_a, in_b, in_mode, in_shift, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
`ifdef FSHIFT_OVF_EN
    , out_ovf
`endif
  );

  modport slave (
    input  in_valid, in_a, in_b, in_mode, in_shift, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
`ifdef FSHIFT_OVF_EN
    , out_ovf
`endif
  );

endinterface

// File: rtl/funnel_shift_pipe_stage.sv
// One pipeline stage: conditionally shifts/rotates by 2**STAGE and registers the result.
// Overflow accumulation is built only when FSHIFT_OVF_EN is defined.
module funnel_stage
  import funnel_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  parameter int STAGE = 0,
  parameter int SH_W  = $clog2(2 * WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_en,
  input  logic               i_valid,
  input  logic [2*WIDTH-1:0] i_data,
  input  logic [MODE_W-1:0]  i_mode,
  input  logic [SH_W-1:0]    i_shift,
  input  logic [TAG_W-1:0]   i_tag,
`ifdef FSHIFT_OVF_EN
  input  logic               i_ovf,
  output logic               o_ovf,
`endif
  output logic               o_valid,
  output logic [2*WIDTH-1:0] o_data,
  output logic [MODE_W-1:0]  o_mode,
  output logic [SH_W-1:0]    o_shift,
  output logic [TAG_W-1:0]   o_tag
);
  localparam int DW  = 2 * WIDTH;
  localparam int AMT = 1 << STAGE;

  logic [DW-1:0] w_shifted;

  // NOTE: combinational blocks use blocking '=' and assign a default first, so no latch is inferred.
  always_comb begin
    w_shifted = i_data;
    if (i_shift[STAGE]) begin
      case (i_mode)
        MODE_SLL: w_shifted = i_data << AMT;
        MODE_SRL: w_shifted = i_data >> AMT;
        MODE_SRA: w_shifted = $unsigned($signed(i_data) >>> AMT);
        MODE_ROL: w_shifted = (i_data << AMT) | (i_data >> (DW - AMT));
        MODE_ROR: w_shifted = (i_data >> AMT) | (i_data << (DW - AMT));
        default:  w_shifted = i_data;
      endcase
    end
  end

`ifdef FSHIFT_OVF_EN
  // Bits pushed out this stage: any 1 for logical shifts, any non-sign bit for SRA.
  logic w_lost;
  always_comb begin
    w_lost = 1'b0;
    if (i_shift[STAGE]) begin
      case (i_mode)
        MODE_SLL: w_lost = |i_data[DW-1 -: AMT];
        MODE_SRL: w_lost = |i_data[AMT-1:0];
        MODE_SRA: w_lost = |(i_data[AMT-1:0] ^ {AMT{i_data[DW-1]}});
        default:  w_lost = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       o_ovf <= 1'b0;
    else if (i_en) o_ovf <= i_ovf | w_lost;
  end
`endif

  // NOTE: datapath registers are cleared with the valid bit so a reset output never shows stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_mode  <= '0;
      o_shift <= '0;
      o_tag   <= '0;
    end else if (i_en) begin
      o_valid <= i_valid;
      o_data  <= w_shifted;
      o_mode  <= i_mode;
      o_shift <= i_shift;
      o_tag   <= i_tag;
    end
  end

endmodule

// File: rtl/funnel_shift_pipe.sv
// Logarithmic funnel shifter: SH_W registered stages, whole pipe stalls on output backpressure.
// Optional overflow flag enabled by defining FSHIFT_OVF_EN.
module funnel_shift_pipe
  import funnel_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input logic                clk,
  input logic                rst,
  funnel_shift_pipe_if.slave bus
);
  localparam int SH_W = $clog2(2 * WIDTH);
  localparam int DW   = 2 * WIDTH;

  logic              w_en;
  logic              w_valid [SH_W+1];
  logic [DW-1:0]     w_data  [SH_W+1];
  logic [MODE_W-1:0] w_mode  [SH_W+1];
  logic [SH_W-1:0]   w_shift [SH_W+1];
  logic [TAG_W-1:0]  w_tag   [SH_W+1];
`ifdef FSHIFT_OVF_EN
  logic              w_ovf   [SH_W+1];
  assign w_ovf[0] = 1'b0;
`endif

  // A single enable for every stage: nothing moves while a result waits unconsumed.
  assign w_en = !w_valid[SH_W] || bus.out_ready;

  assign w_valid[0] = bus.in_valid;
  assign w_data[0]  = {bus.in_a, bus.in_b};
  assign w_mode[0]  = bus.in_mode;
  assign w_shift[0] = bus.in_shift;
  assign w_tag[0]   = bus.in_tag;

  for (genvar k = 0; k < SH_W; k++) begin : g_stage
    funnel_stage #(
      .WIDTH (WIDTH),
      .TAG_W (TAG_W),
      .STAGE (k),
      .SH_W  (SH_W)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_en    (w_en),
      .i_valid (w_valid[k]),
      .i_data  (w_data[k]),
      .i_mode  (w_mode[k]),
      .i_shift (w_shift[k]),
      .i_tag   (w_tag[k]),
`ifdef FSHIFT_OVF_EN
      .i_ovf   (w_ovf[k]),
      .o_ovf   (w_ovf[k+1]),
`endif
      .o_valid (w_valid[k+1]),
      .o_data  (w_data[k+1]),
      .o_mode  (w_mode[k+1]),
      .o_shift (w_shift[k+1]),
      .o_tag   (w_tag[k+1])
    );
  end

  assign bus.in_ready  = w_en;
  assign bus.out_valid = w_valid[SH_W];
  assign bus.out_data  = w_data[SH_W];
  assign bus.out_tag   = w_tag[SH_W];
`ifdef FSHIFT_OVF_EN
  assign bus.out_ovf   = w_ovf[SH_W];
`endif

endmodule

// File: tb/tb_funnel_shift_pipe.sv
// Directed self-checking bench for funnel_shift_pipe (WIDTH=32, 6-stage pipe).
// Overflow checks are compiled in when FSHIFT_OVF_EN is defined.
module tb_funnel_shift_pipe;
  import funnel_pkg::*;

  localparam int WIDTH = 32;
  localparam int TAG_W = 4;
  localparam int LAT   = 6;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   n_vcyc  = 0;

  logic [63:0]      q_data [$];
  logic [TAG_W-1:0] q_tag  [$];
  int               q_cyc  [$];

  funnel_shift_pipe_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  funnel_shift_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Records every consumed result; sampled mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst && bus.out_valid) n_vcyc++;
    if (!rst && bus.out_valid && bus.out_ready) begin
      q_data.push_back(bus.out_data);
      q_tag.push_back(bus.out_tag);
      q_cyc.push_back(cyc);
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] mode, input logic [63:0] w,
                       input logic [5:0] sh, input logic [TAG_W-1:0] tag);
    bus.in_valid = 1'b1;
    bus.in_mode  = mode;
    bus.in_a     = w[63:32];
    bus.in_b     = w[31:0];
    bus.in_shift = sh;
    bus.in_tag   = tag;
  endtask

  task automatic run_vec(input string name, input logic [2:0] mode, input logic [63:0] w,
                         input logic [5:0] sh, input logic [63:0] exp,
                         input bit ovf_chk, input logic exp_ovf);
    int lat;
    drive(mode, w, sh, 4'hA);
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({name, " latency"}, 64'(lat), 64'(LAT));
    check({name, " data"}, bus.out_data, exp);
    check({name, " tag"}, 64'(bus.out_tag), 64'hA);
`ifdef FSHIFT_OVF_EN
    if (ovf_chk) check({name, " ovf"}, 64'(bus.out_ovf), 64'(exp_ovf));
`else
    if (ovf_chk && exp_ovf === 1'bx) check({name, " ovf"}, 64'd0, 64'd1);
`endif
    tick();
  endtask

  task automatic wait_results(input int n);
    int budget = 60;
    while (q_tag.size() < n && budget > 0) begin
      tick();
      budget--;
    end
    repeat (5) tick();
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_mode   = '0;
    bus.in_shift  = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    tick();
    check("rst out_valid", 64'(bus.out_valid), 64'd0);
    check("rst in_ready", 64'(bus.in_ready), 64'd1);
    check("rst out_data", bus.out_data, 64'd0);
    check("rst out_tag", 64'(bus.out_tag), 64'd0);
    tick();
    rst = 1'b0;
    check("post-rst in_ready", 64'(bus.in_ready), 64'd1);

    // Directed vectors: name, mode, W, shift, expected, check ovf, expected ovf.
    run_vec("sll1",   MODE_SLL, 64'h8000_0001_0000_0000, 6'd1,  64'h0000_0002_0000_0000, 1'b1, 1'b1);
    run_vec("sra4",   MODE_SRA, 64'h8000_0000_0000_0000, 6'd4,  64'hF800_0000_0000_0000, 1'b0, 1'b0);
    run_vec("ror63",  MODE_ROR, 64'h0000_0000_0000_0001, 6'd63, 64'h0000_0000_0000_0002, 1'b1, 1'b0);
    run_vec("rol0",   MODE_ROL, 64'hDEAD_BEEF_0123_4567, 6'd0,  64'hDEAD_BEEF_0123_4567, 1'b1, 1'b0);
    run_vec("srl36",  MODE_SRL, 64'h0000_00F0_0000_0000, 6'd36, 64'h0000_0000_0000_000F, 1'b1, 1'b0);
    run_vec("rol8",   MODE_ROL, 64'h1234_5678_9ABC_DEF0, 6'd8,  64'h3456_789A_BCDE_F012, 1'b1, 1'b0);
    run_vec("sra60",  MODE_SRA, 64'h7000_0000_0000_0000, 6'd60, 64'h0000_0000_0000_0007, 1'b1, 1'b0);
    run_vec("rsvd5",  3'd5,     64'hCAFE_BABE_0000_0001, 6'd17, 64'hCAFE_BABE_0000_0001, 1'b1, 1'b0);
    run_vec("sll0",   MODE_SLL, 64'hFFFF_FFFF_FFFF_FFFF, 6'd0,  64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    run_vec("ror4",   MODE_ROR, 64'h0000_0000_0000_000F, 6'd4,  64'hF000_0000_0000_0000, 1'b1, 1'b0);
    run_vec("sll32",  MODE_SLL, 64'h0000_0000_FFFF_FFFF, 6'd32, 64'hFFFF_FFFF_0000_0000, 1'b1, 1'b0);
    run_vec("srl1",   MODE_SRL, 64'h0000_0000_0000_0003, 6'd1,  64'h0000_0000_0000_0001, 1'b1, 1'b1);

    // Back-to-back: op i is SLL of 1 by i, tag i.
    q_data.delete(); q_tag.delete(); q_cyc.delete();
    for (int i = 0; i < 10; i++) begin
      drive(MODE_SLL, 64'd1, 6'(i), 4'(i));
      tick();
    end
    bus.in_valid = 1'b0;
    wait_results(10);
    check("b2b count", 64'(q_tag.size()), 64'd10);
    if (q_tag.size() == 10) begin
      check("b2b consecutive", 64'(q_cyc[9] - q_cyc[0]), 64'd9);
      for (int i = 0; i < 10; i++) begin
        check($sformatf("b2b tag%0d", i), 64'(q_tag[i]), 64'(i));
        check($sformatf("b2b data%0d", i), q_data[i], 64'd1 << i);
      end
    end

    // Bubbles between operations must not create extra results.
    q_data.delete(); q_tag.delete(); q_cyc.delete();
    n_vcyc = 0;
    for (int i = 1; i <= 3; i++) begin
      drive(MODE_ROL, 64'h1, 6'(i), 4'(i));
      tick();
      bus.in_valid = 1'b0;
      tick();
    end
    repeat (12) tick();
    check("bubble count", 64'(q_tag.size()), 64'd3);
    check("bubble valid cycles", 64'(n_vcyc), 64'd3);

    // Stall: fill with out_ready low, hold 5 cycles, then drain.
    q_data.delete(); q_tag.delete(); q_cyc.delete();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(MODE_SLL, 64'd1, 6'(i), 4'(i));
      tick();
    end
    bus.in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("stall%0d in_ready", c), 64'(bus.in_ready), 64'd0);
      check($sformatf("stall%0d out_valid", c), 64'(bus.out_valid), 64'd1);
      check($sformatf("stall%0d data", c), bus.out_data, 64'd1);
      check($sformatf("stall%0d tag", c), 64'(bus.out_tag), 64'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    for (int i = 6; i < 10; i++) begin
      drive(MODE_SLL, 64'd1, 6'(i), 4'(i));
      tick();
    end
    bus.in_valid = 1'b0;
    wait_results(10);
    check("stall count", 64'(q_tag.size()), 64'd10);
    if (q_tag.size() == 10) begin
      for (int i = 0; i < 10; i++) begin
        check($sformatf("stall tag%0d", i), 64'(q_tag[i]), 64'(i));
        check($sformatf("stall data%0d", i), q_data[i], 64'd1 << i);
      end
    end

    // Reset with three operations in flight, one already presented.
    q_data.delete(); q_tag.delete(); q_cyc.delete();
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive(MODE_SRL, 64'hFF00, 6'(i), 4'(i));
      tick();
    end
    bus.in_valid = 1'b0;
    repeat (3) tick();
    check("pre-rst out_valid", 64'(bus.out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("async rst out_valid", 64'(bus.out_valid), 64'd0);
    check("async rst in_ready", 64'(bus.in_ready), 64'd1);
    check("async rst out_data", bus.out_data, 64'd0);
    check("async rst out_tag", 64'(bus.out_tag), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    check("rst release in_ready", 64'(bus.in_ready), 64'd1);
    repeat (15) tick();
    check("no stale results", 64'(q_tag.size()), 64'd0);
    check("no stale out_valid", 64'(bus.out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/funnel_shift_pipe.md
FUNNEL_SHIFT_PIPE -- requirements
Module: funnel_shift_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width; the concatenated word is 2*WIDTH; WIDTH is a power of two, at least 4.
REQ-002 SHALL have parameter TAG_W, default 4: width of the sideband tag.
REQ-003 SHALL derive localparam SH_W = $clog2(2*WIDTH), which is both the shift-amount width and the stage count.
REQ-004 clk  input  1  single clock; all state is updated on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  the operation on the in_* ports is offered.
REQ-007 in_ready  output  1  the pipeline can accept the offered operation.
REQ-008 in_a  input  WIDTH  upper half of the concatenated word.
REQ-009 in_b  input  WIDTH  lower half of the concatenated word.
REQ-010 in_mode  input  3  operation: SLL=0, SRL=1, SRA=2, ROL=3, ROR=4; codes 5-7 are reserved.
REQ-011 in_shift  input  SH_W  shift amount.
REQ-012 in_tag  input  TAG_W  tag carried unchanged alongside the operation.
REQ-013 out_valid  output  1  the result on the out_* ports is valid.
REQ-014 out_ready  input  1  the consumer accepts the result.
REQ-015 out_data  output  2*WIDTH  shifted result.
REQ-016 out_tag  output  TAG_W  tag of the operation that produced the result.
REQ-017 out_ovf  output  1  overflow flag; present only when FSHIFT_OVF_EN is defined.

Function
REQ-018 Operand word W = {in_a,in_b}; SLL shifts W left and zero-fills.
REQ-019 SRL shifts W right and zero-fills.
REQ-020 SRA shifts W right and fills with W[2*WIDTH-1].
REQ-021 ROL and ROR rotate W by in_shift modulo 2*WIDTH.
REQ-022 A reserved mode code SHALL pass W through unshifted.
REQ-023 Logarithmic pipeline: stage k (k = 0..SH_W-1) applies a shift of 2^k when bit k of the shift amount is set, and registers its result, its valid bit, the mode, the remaining shift bits and the tag.
REQ-024 Latency SHALL be exactly SH_W cycles from the accept edge to out_valid; this is 6 cycles for WIDTH=32.
REQ-025 An operation is accepted on a clock edge where in_valid && in_ready; a result is consumed on an edge where out_valid && out_ready.
REQ-026 in_ready = !out_valid || out_ready: the whole pipeline stalls together while a result is presented and not consumed.
REQ-027 During a stall, every stage register holds its value; out_data and out_tag stay stable until consumed.
REQ-028 Throughput SHALL be one operation per cycle when out_ready is held high.
REQ-029 Bubbles (cycles with in_valid low) SHALL propagate as invalid stages and SHALL never produce out_valid.
REQ-030 A shift amount of 0 returns W unchanged in every mode.

Reset
REQ-031 rst SHALL asynchronously clear all stage valid bits, out_valid, out_data, out_tag and out_ovf to 0.
REQ-032 Operations in flight when rst asserts SHALL be discarded and produce no output.
REQ-033 in_ready SHALL be 1 while rst is held and in the first cycle after rst releases.

Configuration
REQ-034 With FSHIFT_OVF_EN defined, out_ovf SHALL be 1 when an SLL or SRL operation discards any 1 bit, or an SRA operation discards any bit that differs from the sign bit; out_ovf is accumulated per stage and is 0 for ROL, ROR and reserved codes.
REQ-035 Without FSHIFT_OVF_EN, the out_ovf port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-036 Package funnel_pkg SHALL hold the mode enum shift_mode_e and the mode encodings.
REQ-037 A single sub-module funnel_stage, parametrised by WIDTH and the stage index, SHALL implement one conditional 2^k shift and its register, instantiated SH_W times in a generate loop.

Verification
REQ-038 Reset, then in_a=32'h8000_0001, in_b=0, SLL, in_shift=1 -> after 6 cycles out_data=64'h0000_0002_0000_0000; out_ovf=1 when FSHIFT_OVF_EN is defined.
REQ-039 in_a=32'h8000_0000, in_b=0, SRA, in_shift=4 -> out_data=64'hF800_0000_0000_0000; out_ovf=0.
REQ-040 ROR, in_shift=63, W=64'h1 -> out_data=64'h2; ROL, in_shift=0, W=64'hDEAD_BEEF_0123_4567 -> out_data=64'hDEAD_BEEF_0123_4567.
REQ-041 Issue 10 back-to-back operations with tags 0-9 and out_ready=1 -> 10 consecutive out_valid cycles, tags in order.
REQ-042 Hold out_ready=0 for 5 cycles while results are waiting -> in_ready=0, output stable, no operation lost or duplicated once out_ready returns to 1.
REQ-043 Assert rst with 3 operations in flight -> out_valid=0 at once; no stale result appears after rst releases.
